// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the shared transmitter arbiter.
// master drives requests and tx_status; slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_BITS = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FRAME_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_status;
  logic                          tx_start;
  logic [FRAME_BITS-1:0]         tx_data;
  logic [IW-1:0]                 owner;
  logic                          locked;
  logic                          lock_timeout;

  modport master (
    output req_valid, req_data, req_last,
    output tx_status,
    input  req_ready, tx_start, tx_data,
    input  owner, locked, lock_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last,
    input  tx_status,
    output req_ready, tx_start, tx_data,
    output owner, locked, lock_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between byte-stream requesters,
// with packet locking and a stall timeout on the locked owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_BITS   = 8,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int IW1 = IW + 1;
  localparam int CW  = $clog2(HOLD_TIMEOUT) + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [IW1-1:0] NUM_W   = IW1'(NUM_REQ);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t                state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         owner_q;
  logic [CW-1:0]         hold_cnt;
  logic                  start_q;
  logic                  locked_q;
  logic                  tmo_q;
  logic [FRAME_BITS-1:0] data_q;

  logic [FRAME_BITS-1:0] bytes [NUM_REQ];
  logic [IW-1:0]         win;
  logic                  found;
  logic [IW-1:0]         sel;
  logic [FRAME_BITS-1:0] pick;
  logic                  pick_last;
  logic [NUM_REQ-1:0]    ready;
  logic                  take;
  logic [IW-1:0]         nxt_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign bytes[g] = bus.req_data[g*FRAME_BITS +: FRAME_BITS];
  end

  // First valid at or above rr_ptr, wrapping with an explicit modulo.
  always_comb begin : rr_scan
    logic [IW1-1:0] sum;
    logic [IW-1:0]  cand;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + IW1'(k);
      if (sum >= NUM_W)
        sum = sum - NUM_W;
      cand = sum[IW-1:0];
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign sel       = (state == HOLD) ? owner_q : win;
  assign pick      = bytes[sel];
  assign pick_last = bus.req_last[sel];

  // No grant in the cycle lock_timeout is visible.
  always_comb begin
    ready = '0;
    if (reset_n && !bus.tx_status) begin
      case (state)
        IDLE:    if (found && !tmo_q) ready[win] = 1'b1;
        HOLD:    ready[owner_q] = 1'b1;
        default: ready = '0;
      endcase
    end
  end

  assign take    = |(ready & bus.req_valid);
  assign nxt_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_q  <= '0;
      hold_cnt <= '0;
      start_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            data_q   <= pick;
            start_q  <= 1'b1;
            owner_q  <= win;
            locked_q <= !pick_last;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.tx_status)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.tx_status) begin
            if (locked_q) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              rr_ptr <= nxt_ptr;
              state  <= IDLE;
            end
          end
        end
        HOLD: begin
          if (take) begin
            data_q   <= pick;
            start_q  <= 1'b1;
            locked_q <= !pick_last;
            hold_cnt <= '0;
            state    <= WAIT_ACK;
          end else if (hold_cnt == HOLD_END) begin
            locked_q <= 1'b0;
            tmo_q    <= 1'b1;
            rr_ptr   <= nxt_ptr;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ready;
  assign bus.tx_start     = start_q;
  assign bus.tx_data      = data_q;
  assign bus.owner        = owner_q;
  assign bus.locked       = locked_q;
  assign bus.lock_timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int FB = 8;
  localparam int HT = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .FRAME_BITS(FB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .FRAME_BITS(FB),
    .HOLD_TIMEOUT(HT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp;
  int n_bad;
  int cyc;

  // per-requester byte queues: {last, data}
  logic [8:0] qb [NR][64];
  int qh [NR];
  int qt [NR];
  logic [NR-1:0] en;
  bit rnd;
  bit force_busy;

  // uart_tx behaviour
  bit ubusy;
  bit udelay;
  bit s_start;
  int ucnt;

  // reference model
  int m_ptr;
  bit m_lock;
  bit m_avail;
  bit m_seen;
  int m_idle;
  logic e_start;
  logic e_locked;
  logic e_tmo;
  logic [FB-1:0] e_data;
  int e_owner;
  int hold_entry;
  int tmo_cyc;

  int gq [512];
  int gn;
  logic [7:0] sq [512];
  int sn;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    qb[i][qt[i] % 64] = {l, d};
    qt[i]++;
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      h = (qt[i] != qh[i]) ? qb[i][qh[i] % 64] : 9'h0;
      bus.req_valid[i] = en[i] && (qt[i] != qh[i]);
      bus.req_last[i] = h[8];
      bus.req_data[i*FB +: FB] = h[7:0];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_lock = 0;
    m_avail = 1;
    m_seen = 0;
    m_idle = 0;
    e_start = 0;
    e_locked = 0;
    e_tmo = 0;
    e_data = '0;
    e_owner = 0;
  endtask

  task automatic uart_reset();
    ubusy = 0;
    udelay = 0;
    s_start = 0;
    ucnt = 0;
  endtask

  task automatic step();
    logic [NR-1:0] er;
    logic [NR-1:0] hs;
    logic [NR-1:0] mx;
    bit found;
    bit nt;
    int w;
    int x;
    int len;
    @(negedge clk);
    cyc++;
    er = '0;
    found = 0;
    if (m_avail && !bus.tx_status) begin
      if (m_lock) begin
        er[e_owner] = 1'b1;
      end else if (!e_tmo) begin
        for (int k = 0; k < NR; k++) begin
          w = (m_ptr + k) % NR;
          if (!found && bus.req_valid[w]) begin
            found = 1;
            er[w] = 1'b1;
          end
        end
      end
    end
    chk("req_ready", bus.req_ready, er);
    chk("tx_start", bus.tx_start, e_start);
    chk("tx_data", bus.tx_data, e_data);
    chk("owner", bus.owner, e_owner);
    chk("locked", bus.locked, e_locked);
    chk("lock_timeout", bus.lock_timeout, e_tmo);
    if (bus.tx_start) begin
      sq[sn % 512] = bus.tx_data;
      sn++;
    end
    if (bus.lock_timeout) tmo_cyc = cyc;
    s_start = bus.tx_start;
    hs = bus.req_valid & bus.req_ready;
    for (int i = 0; i < NR; i++)
      if (hs[i]) begin
        gq[gn % 512] = i;
        gn++;
      end
    mx = bus.req_valid & er;
    e_start = 0;
    nt = 0;
    if (mx != '0) begin
      x = 0;
      for (int i = 0; i < NR; i++) if (mx[i]) x = i;
      e_data = bus.req_data[x*FB +: FB];
      e_owner = x;
      m_lock = !bus.req_last[x];
      m_avail = 0;
      m_seen = 0;
      m_idle = 0;
      e_start = 1;
    end else if (!m_avail) begin
      if (!m_seen) begin
        if (bus.tx_status) m_seen = 1;
      end else if (!bus.tx_status) begin
        m_avail = 1;
        m_idle = 0;
        if (m_lock) hold_entry = cyc + 1;
        else m_ptr = (e_owner + 1) % NR;
      end
    end else if (m_lock) begin
      if (m_idle == HT - 1) begin
        m_lock = 0;
        nt = 1;
        m_ptr = (e_owner + 1) % NR;
      end else begin
        m_idle++;
      end
    end
    e_tmo = nt;
    e_locked = m_lock;
    @(posedge clk);
    #1;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) ubusy = 0;
    end
    if (udelay) begin
      udelay = 0;
      ubusy = 1;
      ucnt = $urandom_range(1, 5);
    end
    if (s_start) udelay = 1;
    for (int i = 0; i < NR; i++) if (hs[i]) qh[i]++;
    if (rnd) begin
      for (int i = 0; i < NR; i++) begin
        if (qt[i] == qh[i] && $urandom % 4 == 0) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++)
            push(i, 8'($urandom), j == len - 1);
        end
        if ($urandom % 16 == 0) en[i] = ~en[i];
      end
      force_busy = ($urandom % 20 == 0);
    end
    bus.tx_status = ubusy | force_busy;
    drive();
  endtask

  task automatic wait_grants(input int n, input string tag);
    int lim;
    lim = 0;
    while (gn < n && lim < 400) begin
      step();
      lim++;
    end
    chk(tag, gn >= n, 1);
  endtask

  task automatic drain(input string tag);
    int lim;
    bit done;
    lim = 0;
    done = 0;
    while (!done && lim < 600) begin
      step();
      lim++;
      done = m_avail && !m_lock && !e_tmo && !e_start && !bus.tx_status;
      for (int i = 0; i < NR; i++)
        if (qt[i] != qh[i]) done = 0;
    end
    chk(tag, done, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_owner"}, bus.owner, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_lock_timeout"}, bus.lock_timeout, 0);
  endtask

  initial begin
    int g0;
    int s0;
    int lim;
    bit ok;
    int rr_exp [5];
    int pk_g [5];
    logic [7:0] pk_d [5];
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    gn = 0;
    sn = 0;
    en = '1;
    rnd = 0;
    force_busy = 0;
    hold_entry = -1;
    tmo_cyc = -1;
    for (int i = 0; i < NR; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    uart_reset();
    model_reset();
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_status = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // round-robin over continuously valid single-byte packets
    g0 = gn;
    for (int i = 0; i < NR; i++) begin
      push(i, 8'(8'h20 + i), 1);
      push(i, 8'(8'h30 + i), 1);
    end
    drive();
    wait_grants(g0 + 5, "rr_wait");
    rr_exp = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_grant%0d", k), gq[(g0 + k) % 512], rr_exp[k]);
    drain("rr_drain");

    // single byte from req0, then pointer must have moved to req1
    g0 = gn;
    s0 = sn;
    push(0, 8'hA5, 1);
    drive();
    wait_grants(g0 + 1, "single_wait");
    chk("single_owner", gq[g0 % 512], 0);
    drain("single_drain");
    chk("single_data", sq[s0 % 512], 8'hA5);
    g0 = gn;
    push(0, 8'h01, 1);
    push(1, 8'h02, 1);
    drive();
    wait_grants(g0 + 2, "ptr_wait");
    chk("ptr_first", gq[g0 % 512], 1);
    chk("ptr_second", gq[(g0 + 1) % 512], 0);
    drain("ptr_drain");

    // packet lock: req2 keeps the transmitter for its whole packet
    g0 = gn;
    s0 = sn;
    push(2, 8'h10, 0);
    push(2, 8'h11, 0);
    push(2, 8'h12, 1);
    drive();
    wait_grants(g0 + 1, "pkt_first");
    push(0, 8'h40, 1);
    push(1, 8'h41, 1);
    drive();
    wait_grants(g0 + 5, "pkt_wait");
    drain("pkt_drain");
    pk_g = '{2, 2, 2, 0, 1};
    pk_d = '{8'h10, 8'h11, 8'h12, 8'h40, 8'h41};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pkt_grant%0d", k), gq[(g0 + k) % 512], pk_g[k]);
      chk($sformatf("pkt_data%0d", k), sq[(s0 + k) % 512], pk_d[k]);
    end

    // stalled owner is force-released after HT idle hold cycles
    g0 = gn;
    push(1, 8'h55, 0);
    drive();
    wait_grants(g0 + 1, "tmo_first");
    hold_entry = -1;
    tmo_cyc = -1;
    push(0, 8'h60, 1);
    push(2, 8'h62, 1);
    drive();
    lim = 0;
    while (tmo_cyc < 0 && lim < 100) begin
      step();
      lim++;
    end
    chk("tmo_seen", tmo_cyc >= 0, 1);
    chk("tmo_delay", tmo_cyc - hold_entry, HT);
    wait_grants(g0 + 2, "tmo_next_wait");
    chk("tmo_next", gq[(g0 + 1) % 512], 2);
    drain("tmo_drain");

    // back-pressure: busy transmitter blocks every grant
    g0 = gn;
    s0 = sn;
    force_busy = 1;
    bus.tx_status = 1'b1;
    for (int i = 0; i < NR; i++) push(i, 8'(8'h70 + i), 1);
    drive();
    repeat (10) step();
    chk("bp_grants", gn - g0, 0);
    chk("bp_starts", sn - s0, 0);
    force_busy = 0;
    wait_grants(g0 + 1, "bp_release_wait");
    chk("bp_release", gq[g0 % 512], 1);
    drain("bp_drain");

    // reset during WAIT_DONE of a locked packet
    g0 = gn;
    push(3, 8'h80, 0);
    push(3, 8'h81, 0);
    push(3, 8'h82, 1);
    push(0, 8'h90, 1);
    drive();
    lim = 0;
    ok = 0;
    while (!ok && lim < 100) begin
      step();
      lim++;
      ok = m_lock && m_seen && !m_avail;
    end
    chk("rst_reach", ok, 1);
    chk("rst_owner_before", gq[g0 % 512], 3);
    reset_n = 1'b0;
    uart_reset();
    model_reset();
    bus.tx_status = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      qh[i] = qt[i];
      push(i, 8'(8'hB0 + i), 1);
    end
    drive();
    g0 = gn;
    wait_grants(g0 + 1, "rst_wait");
    chk("rst_priority", gq[g0 % 512], 0);
    drain("rst_drain");

    // random traffic
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    force_busy = 0;
    en = '1;
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `uart_tx` transmitter among `NUM_REQ` byte-stream requesters (debug console, status reporter, etc.) using round-robin arbitration with packet locking. A requester that wins keeps the transmitter until it delivers a byte flagged `last`, or until it stalls for `HOLD_TIMEOUT` cycles. The block drives `uart_tx`'s `start`/`tx_input` and paces itself from `tx_status`. It sits between the requesters and `uart_tx` in the same clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FRAME_BITS`, 8: byte width; must match `uart_tx`.
- `HOLD_TIMEOUT`, 1024: idle cycles allowed for a locked owner before the lock is released, ≥2.
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  NUM_REQ*FRAME_BITS  byte for requester i at `[i*FRAME_BITS +: FRAME_BITS]`.
- `req_last`  in  NUM_REQ  byte for requester i ends its packet.
- `req_ready`  out  NUM_REQ  one-hot-or-zero accept strobe; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_status`  in  1  from `uart_tx`: 1 = busy, 0 = ready.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  FRAME_BITS  byte to `uart_tx.tx_input`.
- `owner`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `locked`  out  1  a packet is in progress.
- `lock_timeout`  out  1  one-cycle pulse when a lock is force-released.

## Operation
- States: IDLE, WAIT_ACK, WAIT_DONE, HOLD.
- **IDLE**
  - If `tx_status==0` and any `req_valid` is high, the winner is the first set bit scanning from `rr_ptr` upward, with wrap-around.
  - `req_ready[winner]=1` combinationally in that cycle.
  - On the edge:
    - `tx_data <= byte`.
    - `tx_start <= 1`.
    - `owner <= winner`.
    - `locked <= !req_last[winner]`.
    - go to WAIT_ACK.
  - If `tx_status==1`, no `req_ready` is asserted.
- **WAIT_ACK**: `tx_start` returns to 0 (a single-cycle pulse). Stay until `tx_status==1`, then go to WAIT_DONE.
- **WAIT_DONE**: stay until `tx_status==0`.
  - If `locked`: go to HOLD with `hold_cnt <= 0`.
  - Else: `rr_ptr <= (owner+1) mod NUM_REQ`, go to IDLE.
- **HOLD**
  - `req_ready[owner]=1` only, and all other requesters are ignored.
  - If `req_valid[owner]`: accept exactly as in IDLE and clear `hold_cnt`.
  - Else `hold_cnt` increments.
  - When `hold_cnt==HOLD_TIMEOUT-1` with no valid:
    - `locked <= 0`.
    - `lock_timeout` pulses.
    - `rr_ptr <= owner+1` (with wrap).
    - go to IDLE.
- Requester rules:
  - `req_valid`/`req_data`/`req_last` must stay stable until accepted.
  - A requester dropping `req_valid` before acceptance is legal. The arbiter re-evaluates every IDLE cycle and keeps no sticky grant before acceptance.
- `rr_ptr` wraps from `NUM_REQ-1` to 0. For non-power-of-two `NUM_REQ`, the modulo is explicit.
- `hold_cnt` is sized `$clog2(HOLD_TIMEOUT)+1` and never wraps.

## Timing
- Reset values: `tx_start=0`, `tx_data=0`, `owner=0`, `locked=0`, `lock_timeout=0`, `req_ready=0`, state IDLE, `rr_ptr=0`, `hold_cnt=0`.
- `reset_n` low mid-transfer returns all state to these values immediately. No partial packet resumes.
- Accept at edge E:
  - `tx_start` is high exactly in cycle E..E+1.
  - `tx_data` is valid from E and held until the next accept.
- `uart_tx` raises `tx_status` 2 cycles after E. WAIT_ACK has no timeout.
- Earliest next accept is the first cycle in which `tx_status==0` is observed in IDLE/HOLD. There is 1 cycle of turnaround after `uart_tx` returns to IDLE.
- A request arriving in the same cycle as `lock_timeout` is not accepted that cycle. It competes in IDLE on the next cycle.
- A timeout and a valid from the owner in the same cycle: the valid wins, and there is no timeout.

## Test plan
- **Single byte**: req0 sends 0xA5 with `last=1` → one `tx_start` pulse, `tx_data=0xA5`, `locked=0` after the accept, and `rr_ptr=1` after `tx_status` falls.
- **Round-robin**: all 4 requesters continuously valid, single-byte packets → grant order 0,1,2,3,0. No requester is granted twice in a row.
- **Packet lock**: req2 sends 0x10, 0x11, 0x12 (last on 0x12) while req0 and req1 stay valid → three consecutive bytes from req2 before any other grant, with `locked` high until the 0x12 accept.
- **Timeout**: `HOLD_TIMEOUT=8`, req1 sends 0x55 with `last=0`, then drops valid → `lock_timeout` pulses exactly 8 cycles after HOLD entry, and the next grant goes to req2 if it is valid.
- **Back-pressure**: `tx_status` held high by the model → no `req_ready` and no `tx_start` until it falls.
- **Reset mid-packet**: assert `reset_n` low during WAIT_DONE of a locked packet → all outputs return to reset values within the same cycle, and after release req0 has priority.
